// File: rtl/nios_jtag_cmd_sequencer_pkg.sv
// Shared definitions for the Nios II JTAG debug bridge: instruction codes and
// the default payload geometry of the classic 38-bit data register.
package nios_jtag_pkg;

  typedef enum logic [1:0] {
    OCIMEM    = 2'd0,
    TRACEMEM  = 2'd1,
    BREAK     = 2'd2,
    TRACECTRL = 2'd3
  } jtag_instr_e;

  localparam int DEF_DATA_W  = 38;
  localparam int DEF_ACT_BIT = 37;

endpackage

// File: rtl/nios_jtag_cmd_sequencer_tgl_sync.sv
// Brings a TCK-domain toggle into clk and turns each of its edges into a
// single-cycle event.
module nios_jtag_tgl_sync
  import nios_jtag_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tgl,
  output logic o_evt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_tgl};
  end

  // History follows the synced level in reset too, so a toggle resting at 1
  // produces no edge when reset is released.
  always_ff @(posedge i_clk) begin
    r_hist <= r_sync[SYNC_STAGES-1];
  end

  assign o_evt = (r_sync[SYNC_STAGES-1] ^ r_hist) & ~i_reset;

endmodule

// File: rtl/nios_jtag_cmd_sequencer.sv
// System-clock side of the JTAG debug bridge: queues Update-DR commands with
// backpressure and a sticky overflow flag, and latches Capture-DR readback.
module nios_jtag_cmd_sequencer
  import nios_jtag_pkg::*;
#(
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int IR_W        = 2,
  parameter  int ACT_BIT     = DEF_ACT_BIT,
  parameter  int SYNC_STAGES = 2,
  parameter  int FIFO_DEPTH  = 4,
  localparam int NUM_CMD     = 2**IR_W,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      jtag_upd_tgl,
  input  logic                      jtag_cap_tgl,
  input  logic [IR_W-1:0]           jtag_ir,
  input  logic [DATA_W-1:0]         jtag_sr,
  input  logic [NUM_CMD*DATA_W-1:0] status_in,
  input  logic                      cmd_ready,
  input  logic                      ovf_clr,
  output logic                      cmd_valid,
  output logic [DATA_W-1:0]         jdo,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [NUM_CMD-1:0]        take_action,
  output logic [NUM_CMD-1:0]        take_no_action,
  output logic [DATA_W-1:0]         cap_data,
  output logic [LVL_W-1:0]          level,
  output logic                      ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic w_upd_evt;
  logic w_cap_evt;

  nios_jtag_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_upd_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_tgl   (jtag_upd_tgl),
    .o_evt   (w_upd_evt)
  );

  nios_jtag_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cap_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_tgl   (jtag_cap_tgl),
    .o_evt   (w_cap_evt)
  );

  logic [IR_W-1:0]   r_mem_ir  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_dat [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_ovf;
  logic [DATA_W-1:0] r_cap;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [NUM_CMD-1:0] w_sel;
  logic [DATA_W-1:0] w_status [NUM_CMD];

  for (genvar k = 0; k < NUM_CMD; k++) begin : g_status
    assign w_status[k] = status_in[k*DATA_W +: DATA_W];
  end

  assign cmd_valid = (r_level != '0);
  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop     = cmd_valid & cmd_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push    = w_upd_evt & (~w_full | w_pop);
  assign w_drop    = w_upd_evt & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_ir[i]  <= '0;
        r_mem_dat[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_cap    <= '0;
    end else begin
      if (w_push) begin
        r_mem_ir[r_wr_ptr]  <= jtag_ir;
        r_mem_dat[r_wr_ptr] <= jtag_sr;
        r_wr_ptr            <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_cap_evt) begin
        r_cap <= w_status[jtag_ir];
      end
    end
  end

  assign jdo      = r_mem_dat[r_rd_ptr];
  assign cmd_ir   = r_mem_ir[r_rd_ptr];
  assign level    = r_level;
  assign ovf      = r_ovf;
  assign cap_data = r_cap;

  always_comb begin
    w_sel         = '0;
    w_sel[cmd_ir] = 1'b1;
  end

  assign take_action    = (w_pop &  jdo[ACT_BIT]) ? w_sel : '0;
  assign take_no_action = (w_pop & ~jdo[ACT_BIT]) ? w_sel : '0;

endmodule

// File: tb/tb_nios_jtag_cmd_sequencer.sv
// Bench for nios_jtag_cmd_sequencer: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_nios_jtag_cmd_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         jtag_upd_tgl = 1'b0;
  logic         jtag_cap_tgl = 1'b0;
  logic [1:0]   jtag_ir = '0;
  logic [37:0]  jtag_sr = '0;
  logic [151:0] status_in = '0;
  logic         cmd_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic         cmd_valid;
  logic [37:0]  jdo;
  logic [1:0]   cmd_ir;
  logic [3:0]   take_action;
  logic [3:0]   take_no_action;
  logic [37:0]  cap_data;
  logic [2:0]   level;
  logic         ovf;

  nios_jtag_cmd_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .jtag_upd_tgl   (jtag_upd_tgl),
    .jtag_cap_tgl   (jtag_cap_tgl),
    .jtag_ir        (jtag_ir),
    .jtag_sr        (jtag_sr),
    .status_in      (status_in),
    .cmd_ready      (cmd_ready),
    .ovf_clr        (ovf_clr),
    .cmd_valid      (cmd_valid),
    .jdo            (jdo),
    .cmd_ir         (cmd_ir),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .cap_data       (cap_data),
    .level          (level),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ir;
    logic [37:0] sr;
  } cmd_t;

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] sr;
    logic [3:0]  act;
    logic [3:0]  noact;
  } vec_t;

  int total = 0;
  int bad = 0;

  vec_t        vecs [6];
  cmd_t        s3 [5];
  cmd_t        q [$];
  logic [37:0] m_status [4];
  logic [37:0] cap_exp;
  logic [1:0]  slot_ir;
  logic [3:0]  e_act, e_noact;
  int          cyc, next_slot, pend_upd_at, pend_cap_at, ready_pct;
  logic        m_ovf, m_pop, m_full, m_clr;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [1:0] ir, input logic [37:0] sr);
    jtag_ir = ir;
    jtag_sr = sr;
    jtag_upd_tgl = ~jtag_upd_tgl;
  endtask

  task automatic push_and_settle(input cmd_t c);
    upd(c.ir, c.sr);
    repeat (4) tick();
  endtask

  task automatic drain_expect(input cmd_t c, input string nm);
    cmd_ready = 1'b1;
    #1;
    chk({nm, "_valid"}, 64'(cmd_valid), 64'(1'b1));
    chk({nm, "_jdo"}, 64'(jdo), 64'(c.sr));
    chk({nm, "_ir"}, 64'(cmd_ir), 64'(c.ir));
    chk({nm, "_take"}, 64'({take_action, take_no_action}),
        64'(c.sr[37] ? {4'b0001 << c.ir, 4'b0000} : {4'b0000, 4'b0001 << c.ir}));
    tick();
    cmd_ready = 1'b0;
  endtask

  function automatic logic [37:0] rnd38();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  initial begin
    vecs[0] = '{ir: 2'd0, sr: 38'h00_0000_0001, act: 4'b0000, noact: 4'b0001};
    vecs[1] = '{ir: 2'd1, sr: 38'h20_0000_0000, act: 4'b0010, noact: 4'b0000};
    vecs[2] = '{ir: 2'd2, sr: 38'h25_1234_5678, act: 4'b0100, noact: 4'b0000};
    vecs[3] = '{ir: 2'd3, sr: 38'h1F_FFFF_FFFF, act: 4'b0000, noact: 4'b1000};
    vecs[4] = '{ir: 2'd3, sr: 38'h3F_FFFF_FFFF, act: 4'b1000, noact: 4'b0000};
    vecs[5] = '{ir: 2'd1, sr: 38'h00_0000_0000, act: 4'b0000, noact: 4'b0010};
    s3[0] = '{ir: 2'd0, sr: 38'h01_1111_1111};
    s3[1] = '{ir: 2'd1, sr: 38'h22_2222_2222};
    s3[2] = '{ir: 2'd2, sr: 38'h03_3333_3333};
    s3[3] = '{ir: 2'd3, sr: 38'h24_4444_4444};
    s3[4] = '{ir: 2'd1, sr: 38'h35_5555_5555};

    // Reset with both toggles moving to 1 while held in reset.
    repeat (2) tick();
    jtag_upd_tgl = 1'b1;
    jtag_cap_tgl = 1'b1;
    cmd_ready = 1'b1;
    repeat (4) tick();
    chk("rst_valid", 64'(cmd_valid), 64'(1'b0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(1'b0));
    chk("rst_cap", 64'(cap_data), 64'(0));
    chk("rst_jdo", 64'(jdo), 64'(0));
    chk("rst_ir", 64'(cmd_ir), 64'(0));
    chk("rst_take", 64'({take_action, take_no_action}), 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_valid", 64'(cmd_valid), 64'(1'b0));
      chk("post_rst_cap", 64'(cap_data), 64'(0));
    end

    // Vector table: single update with ready held, latency and pulse shape.
    for (int v = 0; v < 6; v++) begin
      cmd_ready = 1'b1;
      upd(vecs[v].ir, vecs[v].sr);
      repeat (2) tick();
      chk("vec_early_valid", 64'(cmd_valid), 64'(1'b0));
      tick();
      chk("vec_valid", 64'(cmd_valid), 64'(1'b1));
      chk("vec_jdo", 64'(jdo), 64'(vecs[v].sr));
      chk("vec_ir", 64'(cmd_ir), 64'(vecs[v].ir));
      chk("vec_act", 64'(take_action), 64'(vecs[v].act));
      chk("vec_noact", 64'(take_no_action), 64'(vecs[v].noact));
      tick();
      chk("vec_after_valid", 64'(cmd_valid), 64'(1'b0));
      chk("vec_after_take", 64'({take_action, take_no_action}), 64'(0));
    end
    cmd_ready = 1'b0;

    // Five updates into a depth-4 queue with no consumer.
    for (int i = 0; i < 5; i++) push_and_settle(s3[i]);
    chk("ovf_level", 64'(level), 64'(4));
    chk("ovf_flag", 64'(ovf), 64'(1'b1));
    for (int i = 0; i < 4; i++) drain_expect(s3[i], "ovf_drain");
    chk("ovf_empty", 64'(cmd_valid), 64'(1'b0));
    chk("ovf_empty_lvl", 64'(level), 64'(0));

    // Full queue with push and pop landing in the same cycle.
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_ovf", 64'(ovf), 64'(1'b0));
    for (int i = 0; i < 4; i++) push_and_settle(s3[i]);
    upd(s3[4].ir, s3[4].sr);
    repeat (2) tick();
    cmd_ready = 1'b1;
    #1;
    chk("fullpp_take", 64'({take_action, take_no_action}), 64'({4'b0000, 4'b0001}));
    tick();
    cmd_ready = 1'b0;
    chk("fullpp_level", 64'(level), 64'(4));
    chk("fullpp_ovf", 64'(ovf), 64'(1'b0));
    for (int i = 1; i < 5; i++) drain_expect(s3[i], "fullpp_drain");
    chk("fullpp_empty", 64'(cmd_valid), 64'(1'b0));

    // Capture plus simultaneous update on instruction 1.
    status_in = {38'h0A_0000_0003, 38'h0B_0000_0002, 38'h3F_0000_00A5, 38'h0D_0000_0000};
    jtag_cap_tgl = ~jtag_cap_tgl;
    upd(2'd1, 38'h12_3456_789A);
    repeat (2) tick();
    chk("cap_early", 64'(cap_data), 64'(0));
    tick();
    chk("cap_data", 64'(cap_data), 64'(38'h3F_0000_00A5));
    chk("cap_upd_level", 64'(level), 64'(1));
    drain_expect('{ir: 2'd1, sr: 38'h12_3456_789A}, "cap_upd");

    // Reset flushes a partly filled queue.
    for (int i = 0; i < 3; i++) push_and_settle(s3[i]);
    chk("flush_pre_level", 64'(level), 64'(3));
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    cmd_ready = 1'b1;
    #1;
    chk("flush_level", 64'(level), 64'(0));
    chk("flush_valid", 64'(cmd_valid), 64'(1'b0));
    chk("flush_take", 64'({take_action, take_no_action}), 64'(0));
    tick();
    chk("flush_take2", 64'({take_action, take_no_action}), 64'(0));
    chk("flush_cap", 64'(cap_data), 64'(0));
    cmd_ready = 1'b0;

    // Drop coinciding with ovf_clr keeps the flag set.
    for (int i = 0; i < 5; i++) push_and_settle(s3[i]);
    chk("drop_ovf", 64'(ovf), 64'(1'b1));
    upd(2'd2, 38'h2A_AAAA_AAAA);
    repeat (2) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("drop_clr_ovf", 64'(ovf), 64'(1'b1));
    chk("drop_clr_level", 64'(level), 64'(4));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_only_ovf", 64'(ovf), 64'(1'b0));

    // Randomized traffic against the reference model.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    cap_exp = '0;
    for (int k = 0; k < 4; k++) m_status[k] = status_in[k*38 +: 38];
    next_slot = 0;
    pend_upd_at = -1;
    pend_cap_at = -1;
    for (cyc = 0; cyc < 4000; cyc++) begin
      chk("rnd_valid", 64'(cmd_valid), 64'(q.size() > 0));
      chk("rnd_level", 64'(level), 64'(q.size()));
      chk("rnd_ovf", 64'(ovf), 64'(m_ovf));
      chk("rnd_cap", 64'(cap_data), 64'(cap_exp));
      if (q.size() > 0) begin
        chk("rnd_jdo", 64'(jdo), 64'(q[0].sr));
        chk("rnd_ir", 64'(cmd_ir), 64'(q[0].ir));
      end

      ready_pct = ((cyc / 500) % 2 == 1) ? 10 : 60;
      cmd_ready = ($urandom_range(0, 99) < ready_pct);
      m_clr = ($urandom_range(0, 99) < 8);
      ovf_clr = m_clr;
      if (cyc >= next_slot) begin
        slot_ir = 2'($urandom_range(0, 3));
        jtag_ir = slot_ir;
        jtag_sr = rnd38();
        if ($urandom_range(0, 3) != 0) begin
          jtag_upd_tgl = ~jtag_upd_tgl;
          pend_upd_at = cyc + 2;
        end
        if ($urandom_range(0, 1) == 1) begin
          for (int k = 0; k < 4; k++) begin
            m_status[k] = rnd38();
            status_in[k*38 +: 38] = m_status[k];
          end
          jtag_cap_tgl = ~jtag_cap_tgl;
          pend_cap_at = cyc + 2;
        end
        next_slot = cyc + 4 + int'($urandom_range(0, 3));
      end
      #1;
      e_act = '0;
      e_noact = '0;
      m_pop = (q.size() > 0) && cmd_ready;
      if (m_pop) begin
        if (q[0].sr[37]) e_act = 4'b0001 << q[0].ir;
        else e_noact = 4'b0001 << q[0].ir;
      end
      chk("rnd_act", 64'(take_action), 64'(e_act));
      chk("rnd_noact", 64'(take_no_action), 64'(e_noact));

      m_full = (q.size() == 4);
      if (m_pop) void'(q.pop_front());
      if (pend_upd_at == cyc) begin
        if (!m_full || m_pop) q.push_back('{ir: jtag_ir, sr: jtag_sr});
        else m_ovf = 1'b1;
      end else if (m_clr) begin
        m_ovf = 1'b0;
      end
      if (pend_upd_at == cyc && (!m_full || m_pop) && m_clr) m_ovf = 1'b0;
      if (pend_cap_at == cyc) cap_exp = m_status[jtag_ir];
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
